// File: rtl/ahbl_sram_slave_if.sv
// ahbl_sram_slave_if: AHB-Lite signal bundle between one master and the SRAM responder
interface ahbl_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahbl_sram_slave.sv
// ahbl_sram_slave: AHB-Lite responder over a word SRAM with wait states and two-cycle ERROR
module ahbl_sram_slave #(
    parameter int AW = 10,
    parameter int WAIT_STATES = 0
) (
    input logic HCLK,
    input logic HRESETn,
    ahbl_sram_slave_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic [AW+1:0] addr_q;
    logic [2:0] size_q;
    logic wr_q, accept, illegal, done, load;
    logic [3:0] be;
    logic [31:0] mem [2**AW];

    assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign illegal = bus.HSIZE > 3'd2 || (bus.HSIZE == 3'd1 && bus.HADDR[0]) ||
                     (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'd0);
    assign done = state == DATA && cnt == 3'd0;
    // a new address phase is only taken when no data phase is stalling the bus
    assign load = accept && (state == IDLE || state == ERR2 || done);

    always_comb begin
        state_nx = IDLE;
        cnt_nx = '0;
        if (load) begin
            state_nx = illegal ? ERR1 : DATA;
            cnt_nx = illegal ? 3'd0 : WS;
        end else if (state == ERR1) begin
            state_nx = ERR2;
        end else if (state == DATA && cnt != 3'd0) begin
            state_nx = DATA;
            cnt_nx = cnt - 3'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
            cnt <= '0;
            addr_q <= '0;
            size_q <= '0;
            wr_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (load) begin
                addr_q <= bus.HADDR[AW+1:0];
                size_q <= bus.HSIZE;
                wr_q <= bus.HWRITE;
            end
        end
    end

    assign be = size_q == 3'd0 ? 4'b0001 << addr_q[1:0] :
                size_q == 3'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    always_ff @(posedge HCLK) begin
        if (done && wr_q)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= bus.HWDATA[8*i +: 8];
    end

    assign bus.HREADYOUT = state == ERR1 ? 1'b0 : (state != DATA || cnt == 3'd0);
    assign bus.HRESP = state == ERR1 || state == ERR2;
    assign bus.HRDATA = (state == DATA && !wr_q) ? mem[addr_q[AW+1:2]] : 32'd0;
endmodule

// File: tb/tb_ahbl_sram_slave.sv
// tb_ahbl_sram_slave: random and directed AHB-Lite traffic against two responders (0 and 3 wait states)
module tb_ahbl_sram_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahbl_sram_slave_if bus0();
    ahbl_sram_slave_if bus1();

    logic sel;
    logic hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0] htrans;
    logic [2:0] hsize;
    logic ready, resp, other_ready;
    logic [31:0] rdata;

    assign ready = sel ? bus1.HREADYOUT : bus0.HREADYOUT;
    assign other_ready = sel ? bus0.HREADYOUT : bus1.HREADYOUT;
    assign resp = sel ? bus1.HRESP : bus0.HRESP;
    assign rdata = sel ? bus1.HRDATA : bus0.HRDATA;

    assign bus0.HSEL = hsel & ~sel;
    assign bus1.HSEL = hsel & sel;
    assign bus0.HADDR = haddr;
    assign bus1.HADDR = haddr;
    assign bus0.HTRANS = htrans;
    assign bus1.HTRANS = htrans;
    assign bus0.HSIZE = hsize;
    assign bus1.HSIZE = hsize;
    assign bus0.HWRITE = hwrite;
    assign bus1.HWRITE = hwrite;
    assign bus0.HWDATA = hwdata;
    assign bus1.HWDATA = hwdata;
    assign bus0.HREADY = ready;
    assign bus1.HREADY = ready;

    ahbl_sram_slave #(.AW(10), .WAIT_STATES(0)) u_ws0 (.HCLK(clk), .HRESETn(rst_n), .bus(bus0));
    ahbl_sram_slave #(.AW(10), .WAIT_STATES(3)) u_ws3 (.HCLK(clk), .HRESETn(rst_n), .bus(bus1));

    int checks = 0;
    int failures = 0;

    // reference memory: a 64-word window per responder, addressed by HADDR[7:2]
    logic [31:0] mdl [2][64];
    bit p_valid, p_wr, p_legal;
    logic [31:0] p_addr, p_wd, last_rdata;
    int p_sz, p_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a, input int sz);
        return sz <= 2 && (a % (32'd1 << sz)) == 0;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    task automatic observe();
        int ws;
        ws = sel ? 3 : 0;
        chk("unsel_rdy", other_ready, 1);
        if (!p_valid) begin
            chk("idle_rdy", ready, 1);
            chk("idle_resp", resp, 0);
            chk("idle_rdata", rdata, 0);
        end else if (!p_legal) begin
            p_cyc++;
            chk("err_rdy", ready, 32'(p_cyc == 2));
            chk("err_resp", resp, 1);
            chk("err_rdata", rdata, 0);
        end else begin
            p_cyc++;
            chk("data_rdy", ready, 32'(p_cyc > ws));
            chk("data_resp", resp, 0);
            if (ready && p_wr) begin
                chk("wr_rdata", rdata, 0);
                for (int i = 0; i < (1 << p_sz); i++) begin
                    int b;
                    b = int'(p_addr[1:0]) + i;
                    mdl[int'(sel)][widx(p_addr)][8*b +: 8] = p_wd[8*b +: 8];
                end
            end else if (ready) begin
                last_rdata = rdata;
                chk("rd_data", rdata, mdl[int'(sel)][widx(p_addr)]);
            end
        end
    endtask

    // present one address phase (or IDLE/BUSY), hold it until accepted, then start its data phase
    task automatic bus_cycle(input bit valid, input bit busy, input bit wr,
                             input logic [31:0] a, input int sz, input logic [31:0] wd);
        int n;
        hsel = valid | busy;
        htrans = valid ? 2'b10 : (busy ? 2'b01 : 2'b00);
        haddr = a;
        hsize = 3'(sz);
        hwrite = wr;
        n = 0;
        while (1) begin
            @(negedge clk);
            observe();
            if (ready) break;
            n++;
            if (n > 12) begin
                checks++;
                failures++;
                $display("FAIL stall_bound got=0 exp=1");
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        p_valid = valid;
        p_wr = wr;
        p_addr = a;
        p_sz = sz;
        p_wd = wd;
        p_legal = legal(a, sz);
        p_cyc = 0;
        hwdata = (valid && wr) ? wd : $urandom;
    endtask

    task automatic wr(input logic [31:0] a, input int sz, input logic [31:0] d);
        bus_cycle(1, 0, 1, a, sz, d);
    endtask

    task automatic rd(input logic [31:0] a, input int sz);
        bus_cycle(1, 0, 0, a, sz, 32'd0);
    endtask

    task automatic flush();
        bus_cycle(0, 0, 0, 32'd0, 0, 32'd0);
    endtask

    initial begin
        sel = 1'b0;
        hsel = 1'b0;
        htrans = 2'b00;
        haddr = '0;
        hsize = '0;
        hwrite = 1'b0;
        hwdata = '0;
        p_valid = 0;
        p_wr = 0;
        p_legal = 1;
        p_addr = '0;
        p_wd = '0;
        p_sz = 0;
        p_cyc = 0;
        last_rdata = '0;
        #12;
        chk("rst_rdy0", bus0.HREADYOUT, 1);
        chk("rst_resp0", bus0.HRESP, 0);
        chk("rst_rdata0", bus0.HRDATA, 0);
        chk("rst_rdy3", bus1.HREADYOUT, 1);
        chk("rst_resp3", bus1.HRESP, 0);
        chk("rst_rdata3", bus1.HRDATA, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < 64; w++) wr(32'(w) << 2, 2, $urandom);
            flush();
        end

        sel = 1'b0;
        wr(32'h0, 2, 32'h12345670);
        rd(32'h0, 2);
        flush();
        chk("plan_word", last_rdata, 32'h12345670);
        wr(32'h4, 2, 32'h11223344);
        wr(32'h5, 0, 32'hAAAAAAAA);
        rd(32'h4, 2);
        flush();
        chk("plan_byte", last_rdata, 32'h1122AA44);
        wr(32'h3, 1, 32'hFFFFFFFF);
        rd(32'h0, 2);
        flush();
        chk("plan_err", last_rdata, 32'h12345670);
        wr(32'h20, 2, 32'hDEADBEEF);
        rd(32'h20, 2);
        flush();
        chk("plan_b2b", last_rdata, 32'hDEADBEEF);

        sel = 1'b1;
        wr(32'h10, 2, 32'h5A5AC3C3);
        rd(32'h10, 2);
        rd(32'h14, 2);
        flush();
        wr(32'h3, 1, 32'h0);
        flush();
        wr(32'h40, 2, 32'h0BADC0DE);
        flush();
        wr(32'h40, 2, 32'hCAFEF00D);
        hsel = 1'b0;
        htrans = 2'b00;
        @(negedge clk);
        observe();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", bus1.HREADYOUT, 1);
        chk("mid_rst_resp", bus1.HRESP, 0);
        chk("mid_rst_rdata", bus1.HRDATA, 0);
        p_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(32'h40, 2);
        flush();
        chk("plan_rst", last_rdata, 32'h0BADC0DE);

        for (int k = 0; k < 400; k++) begin
            int kind, sz;
            logic [31:0] a;
            kind = int'($urandom_range(0, 9));
            sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            if (kind == 0) begin
                flush();
                sel = ~sel;
            end else if (kind == 1) bus_cycle(0, 1, 0, a, 0, 32'd0);
            else if (kind == 2) flush();
            else if (kind < 6) wr(a, sz, $urandom);
            else rd(a, sz);
        end
        flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
